// File: rtl/gcd_pkg.sv
// Shared types for the GCD operand feeder: FSM state encoding, the default
// datapath width and the queued operand-pair layout.
package gcd_pkg;

   localparam int GCD_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      HOLD   = 2'd2
   } gcd_state_t;

   typedef struct packed {
      logic [GCD_WIDTH-1:0] x;
      logic [GCD_WIDTH-1:0] y;
      logic                 clear;
   } gcd_pair_t;

   // Bits needed to store one {x, y, clear} pair of the given operand width.
   function automatic int pairWidth(input int width);
      return 2 * width + 1;
   endfunction

endpackage

// File: rtl/gcd_pair_fifo.sv
// Small power-of-two FIFO holding packed {x, y, clear} operand pairs.
// Full/empty and the occupancy count come straight from registered state.
module gcd_pair_fifo
   import gcd_pkg::*;
#(
   parameter int WIDTH = GCD_WIDTH,
   parameter int DEPTH = 4
) (
   input  logic                        Clk,
   input  logic                        Reset,
   input  logic                        i_push,
   input  logic [pairWidth(WIDTH)-1:0] i_pushData,
   input  logic                        i_pop,
   output logic [pairWidth(WIDTH)-1:0] o_popData,
   output logic [$clog2(DEPTH):0]      o_count,
   output logic                        o_full,
   output logic                        o_empty
);

   localparam int PW = pairWidth(WIDTH);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [PW-1:0] r_mem [DEPTH];
   logic [AW-1:0] r_wrPtr;
   logic [AW-1:0] r_rdPtr;
   logic [CW-1:0] r_count;
   logic          w_doPush;
   logic          w_doPop;

   assign o_full   = (r_count == CW'(DEPTH));
   assign o_empty  = (r_count == '0);
   assign w_doPush = i_push && !o_full;
   assign w_doPop  = i_pop && !o_empty;

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_count <= '0;
      end else begin
         if (w_doPush) begin
            r_wrPtr <= r_wrPtr + 1'b1;
         end
         if (w_doPop) begin
            r_rdPtr <= r_rdPtr + 1'b1;
         end
         case ({w_doPush, w_doPop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge Clk) begin
      if (w_doPush) begin
         r_mem[r_wrPtr] <= i_pushData;
      end
   end

   assign o_popData = r_mem[r_rdPtr];
   assign o_count   = r_count;

endmodule

// File: rtl/gcd_feeder.sv
// Back-pressured operand sequencer for the combinational GCD block: queues
// pairs, drives them onto X/Y/Reset one at a time, and returns the result.
module gcd_feeder
   import gcd_pkg::*;
#(
   parameter int WIDTH         = GCD_WIDTH,
   parameter int DEPTH         = 4,
   parameter int SETTLE_CYCLES = 1
) (
   input  logic                   Clk,
   input  logic                   Reset,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [WIDTH-1:0]       in_x,
   input  logic [WIDTH-1:0]       in_y,
   input  logic                   in_clear,
   output logic [WIDTH-1:0]       X,
   output logic [WIDTH-1:0]       Y,
   output logic                   gcd_reset,
   input  logic [WIDTH-1:0]       gcd_output,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [WIDTH-1:0]       out_x,
   output logic [WIDTH-1:0]       out_y,
   output logic [WIDTH-1:0]       out_gcd,
   output logic [$clog2(DEPTH):0] count
);

   localparam int PW = pairWidth(WIDTH);
   localparam int SW = $clog2(SETTLE_CYCLES + 1);

   logic [PW-1:0]    w_pushData;
   logic [PW-1:0]    w_popData;
   logic             w_full;
   logic             w_empty;
   logic             w_pop;
   logic [WIDTH-1:0] w_headX;
   logic [WIDTH-1:0] w_headY;
   logic             w_headClear;

   gcd_state_t       r_state;
   logic [SW-1:0]    r_settle;
   logic [WIDTH-1:0] r_x;
   logic [WIDTH-1:0] r_y;
   logic             r_gcdReset;
   logic             r_outValid;
   logic [WIDTH-1:0] r_outX;
   logic [WIDTH-1:0] r_outY;
   logic [WIDTH-1:0] r_outGcd;

   assign w_pushData  = {in_x, in_y, in_clear};
   assign w_headX     = w_popData[PW-1 -: WIDTH];
   assign w_headY     = w_popData[WIDTH:1];
   assign w_headClear = w_popData[0];

   // Only IDLE consumes from the queue; HOLD deliberately never pops.
   assign w_pop    = (r_state == IDLE) && !w_empty;
   assign in_ready = !w_full;

   gcd_pair_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .Clk        (Clk),
      .Reset      (Reset),
      .i_push     (in_valid),
      .i_pushData (w_pushData),
      .i_pop      (w_pop),
      .o_popData  (w_popData),
      .o_count    (count),
      .o_full     (w_full),
      .o_empty    (w_empty)
   );

   // GCD reset idles high so the block's output sits at 0 until the first pair.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_state    <= IDLE;
         r_settle   <= '0;
         r_x        <= '0;
         r_y        <= '0;
         r_gcdReset <= 1'b1;
         r_outValid <= 1'b0;
         r_outX     <= '0;
         r_outY     <= '0;
         r_outGcd   <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (!w_empty) begin
                  r_x        <= w_headX;
                  r_y        <= w_headY;
                  r_gcdReset <= w_headClear;
                  r_settle   <= SW'(SETTLE_CYCLES);
                  r_state    <= SETTLE;
               end
            end
            SETTLE: begin
               r_settle <= r_settle - 1'b1;
               if (r_settle == SW'(1)) begin
                  r_outGcd   <= gcd_output;
                  r_outX     <= r_x;
                  r_outY     <= r_y;
                  r_outValid <= 1'b1;
                  r_state    <= HOLD;
               end
            end
            HOLD: begin
               if (out_ready) begin
                  r_outValid <= 1'b0;
                  r_state    <= IDLE;
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign X         = r_x;
   assign Y         = r_y;
   assign gcd_reset = r_gcdReset;
   assign out_valid = r_outValid;
   assign out_x     = r_outX;
   assign out_y     = r_outY;
   assign out_gcd   = r_outGcd;

endmodule

// File: tb/tb_gcd_feeder.sv
// Scoreboard bench for gcd_feeder with a behavioural combinational GCD block
// wired onto its X/Y/gcd_reset outputs.
module tb_gcd_feeder;

   localparam int WIDTH  = 8;
   localparam int DEPTH  = 4;
   localparam int SETTLE = 1;

   logic             Clk = 1'b0;
   logic             Reset;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_x;
   logic [WIDTH-1:0] in_y;
   logic             in_clear;
   logic [WIDTH-1:0] X;
   logic [WIDTH-1:0] Y;
   logic             gcd_reset;
   logic [WIDTH-1:0] gcd_output;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_x;
   logic [WIDTH-1:0] out_y;
   logic [WIDTH-1:0] out_gcd;
   logic [2:0]       count;

   typedef struct {
      logic [WIDTH-1:0] x;
      logic [WIDTH-1:0] y;
      logic [WIDTH-1:0] g;
      logic             clr;
   } expect_t;

   expect_t sbQueue[$];
   int      xferCycles[$];
   int      errCount   = 0;
   int      checkCount = 0;
   int      xferCount  = 0;
   int      cycleCount = 0;

   gcd_feeder #(
      .WIDTH         (WIDTH),
      .DEPTH         (DEPTH),
      .SETTLE_CYCLES (SETTLE)
   ) dut (
      .Clk        (Clk),
      .Reset      (Reset),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_x       (in_x),
      .in_y       (in_y),
      .in_clear   (in_clear),
      .X          (X),
      .Y          (Y),
      .gcd_reset  (gcd_reset),
      .gcd_output (gcd_output),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_x      (out_x),
      .out_y      (out_y),
      .out_gcd    (out_gcd),
      .count      (count)
   );

   always #5 Clk = ~Clk;

   always @(posedge Clk) cycleCount <= cycleCount + 1;

   // Stand-in for the combinational GCD block; a zero operand or reset gives 0.
   function automatic logic [WIDTH-1:0] gcdModel(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b,
                                                 input logic rst);
      logic [WIDTH-1:0] p;
      logic [WIDTH-1:0] q;
      logic [WIDTH-1:0] t;
      if (rst || a == '0 || b == '0) return '0;
      p = a;
      q = b;
      for (int i = 0; i < 32; i++) begin
         if (q != '0) begin
            t = p % q;
            p = q;
            q = t;
         end
      end
      return p;
   endfunction

   always_comb gcd_output = gcdModel(X, Y, gcd_reset);

   task automatic checkOutput(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
      checkCount++;
      if (actual !== expected) begin
         errCount++;
         $display("[TB] FAIL %s: got %0d expected %0d at cycle %0d",
                  tag, actual, expected, cycleCount);
      end
   endtask

   // Offers one pair (called just after a rising edge) and holds it until taken.
   task automatic applyStimulus(input logic [WIDTH-1:0] ax, input logic [WIDTH-1:0] ay,
                                input logic aclr, input logic [WIDTH-1:0] ag);
      bit accepted;
      accepted = 0;
      in_x     = ax;
      in_y     = ay;
      in_clear = aclr;
      in_valid = 1'b1;
      for (int i = 0; i < 200 && !accepted; i++) begin
         @(negedge Clk);
         if (in_ready) begin
            @(posedge Clk);
            sbQueue.push_back('{x: ax, y: ay, g: ag, clr: aclr});
            accepted = 1;
         end
      end
      #1;
      in_valid = 1'b0;
      if (!accepted) checkOutput("inTimeout", 0, 1);
   endtask

   task automatic waitDrain(input int budget);
      for (int i = 0; i < budget && sbQueue.size() != 0; i++) @(posedge Clk);
      repeat (2) @(posedge Clk);
      #1;
      checkOutput("drainTimeout", sbQueue.size(), 0);
   endtask

   // Each negedge with valid&ready is exactly one transfer at the next edge.
   always @(negedge Clk) begin
      expect_t e;
      if (!Reset && out_valid && out_ready) begin
         xferCount++;
         xferCycles.push_back(cycleCount);
         if (sbQueue.size() == 0) begin
            checkOutput("unexpectedResult", 1, 0);
         end else begin
            e = sbQueue.pop_front();
            checkOutput("outX", out_x, e.x);
            checkOutput("outY", out_y, e.y);
            checkOutput("outGcd", out_gcd, e.g);
            checkOutput("gcdResetDuringRun", gcd_reset, e.clr);
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int  xferBefore;
      bit  found;

      Reset     = 1'b1;
      in_valid  = 1'b0;
      in_x      = '0;
      in_y      = '0;
      in_clear  = 1'b0;
      out_ready = 1'b0;
      repeat (3) @(posedge Clk);
      #1;
      checkOutput("rstInReady", in_ready, 1);
      checkOutput("rstCount", count, 0);
      checkOutput("rstOutValid", out_valid, 0);
      checkOutput("rstX", X, 0);
      checkOutput("rstY", Y, 0);
      checkOutput("rstGcdReset", gcd_reset, 1);
      checkOutput("rstOutX", out_x, 0);
      checkOutput("rstOutY", out_y, 0);
      checkOutput("rstOutGcd", out_gcd, 0);
      Reset = 1'b0;
      @(posedge Clk);
      #1;

      $display("[TB] single pair latency");
      out_ready = 1'b1;
      in_x      = 8'd12;
      in_y      = 8'd6;
      in_clear  = 1'b0;
      in_valid  = 1'b1;
      @(posedge Clk);
      sbQueue.push_back('{x: 8'd12, y: 8'd6, g: 8'd6, clr: 1'b0});
      #1;
      in_valid = 1'b0;
      @(negedge Clk);
      checkOutput("latCountAfterPush", count, 1);
      checkOutput("latValidAfterPush", out_valid, 0);
      @(negedge Clk);
      checkOutput("latXLoaded", X, 12);
      checkOutput("latYLoaded", Y, 6);
      checkOutput("latCountAfterPop", count, 0);
      checkOutput("latValidAfterPop", out_valid, 0);
      @(negedge Clk);
      checkOutput("latValidAfterCapture", out_valid, 1);
      checkOutput("latGcd", out_gcd, 6);
      @(posedge Clk);
      #1;

      $display("[TB] back-to-back throughput");
      xferCycles.delete();
      applyStimulus(8'd28, 8'd5, 1'b0, 8'd1);
      applyStimulus(8'd5, 8'd28, 1'b0, 8'd1);
      applyStimulus(8'd158, 8'd38, 1'b0, 8'd2);
      waitDrain(60);
      checkOutput("burstXfers", xferCycles.size(), 3);
      if (xferCycles.size() == 3) begin
         checkOutput("spacing01", xferCycles[1] - xferCycles[0], SETTLE + 2);
         checkOutput("spacing12", xferCycles[2] - xferCycles[1], SETTLE + 2);
      end
      @(posedge Clk);
      #1;

      $display("[TB] clear flag and zero operands");
      applyStimulus(8'd28, 8'd28, 1'b1, 8'd0);
      applyStimulus(8'd28, 8'd28, 1'b0, 8'd28);
      applyStimulus(8'd0, 8'd192, 1'b0, 8'd0);
      applyStimulus(8'd0, 8'd0, 1'b0, 8'd0);
      waitDrain(80);
      @(posedge Clk);
      #1;

      $display("[TB] back-pressure with full queue");
      out_ready = 1'b0;
      fork
         begin
            applyStimulus(8'd48, 8'd18, 1'b0, 8'd6);
            applyStimulus(8'd100, 8'd75, 1'b0, 8'd25);
            applyStimulus(8'd17, 8'd5, 1'b0, 8'd1);
            applyStimulus(8'd81, 8'd27, 1'b1, 8'd0);
            applyStimulus(8'd64, 8'd48, 1'b0, 8'd16);
            applyStimulus(8'd9, 8'd6, 1'b0, 8'd3);
         end
      join_none
      repeat (12) @(posedge Clk);
      @(negedge Clk);
      checkOutput("fullCount", count, DEPTH);
      checkOutput("fullInReady", in_ready, 0);
      checkOutput("fullHeldOffer", in_valid, 1);
      checkOutput("fullOutValid", out_valid, 1);
      checkOutput("fullOutX", out_x, 48);
      @(posedge Clk);
      #1;
      out_ready = 1'b1;
      wait fork;
      waitDrain(100);
      @(posedge Clk);
      #1;

      $display("[TB] reset during settle");
      out_ready = 1'b0;
      fork
         begin
            applyStimulus(8'd30, 8'd12, 1'b0, 8'd6);
            applyStimulus(8'd77, 8'd11, 1'b0, 8'd11);
            applyStimulus(8'd40, 8'd16, 1'b0, 8'd8);
            applyStimulus(8'd35, 8'd21, 1'b0, 8'd7);
            applyStimulus(8'd90, 8'd60, 1'b0, 8'd30);
         end
      join_none
      wait fork;
      @(posedge Clk);
      #1;
      out_ready = 1'b1;
      found = 0;
      for (int i = 0; i < 20 && !found; i++) begin
         @(negedge Clk);
         if (X == 8'd77 && count == 3'd3 && !out_valid) found = 1;
      end
      checkOutput("reachedSettle", found, 1);
      #1;
      Reset = 1'b1;
      #1;
      checkOutput("midRstCount", count, 0);
      checkOutput("midRstOutValid", out_valid, 0);
      checkOutput("midRstGcdReset", gcd_reset, 1);
      checkOutput("midRstInReady", in_ready, 1);
      checkOutput("midRstX", X, 0);
      checkOutput("discardedEntries", sbQueue.size(), 4);
      sbQueue.delete();
      @(posedge Clk);
      #1;
      Reset      = 1'b0;
      xferBefore = xferCount;
      repeat (20) @(posedge Clk);
      #1;
      checkOutput("noStaleResult", xferCount - xferBefore, 0);
      checkOutput("postRstCount", count, 0);
      checkOutput("postRstOutValid", out_valid, 0);

      checkOutput("totalXfers", xferCount, 15);
      checkOutput("scoreboardEmpty", sbQueue.size(), 0);
      $display("Result: errors=%0d of %0d checks", errCount, checkCount);
      $finish;
   end

endmodule
